mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter and sequencer for the core's single synchronous byte-addressed memory. Shares one memory port between the instruction-fetch path (read-only, word) and the load/store path (read/write, byte/halfword/word). Drives the memory command signals from registers, tracks the 1-cycle synchronous read latency, and returns each response to the requester that issued it. Sits between the core's fetch/LSU stages and the memory instance.

## Interface
- ADDR_WIDTH, `ADDR_WIDTH, byte address width
- WORD_WIDTH, `WORD_WIDTH, data width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_WIDTH  fetch byte address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid, 1-cycle pulse
- if_rdata  out  WORD_WIDTH  fetch data
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_unit  in  2  00 byte, 01 halfword, 10 word
- d_addr  in  ADDR_WIDTH  data byte address
- d_wdata  in  WORD_WIDTH  store data, LSBs used for byte/halfword
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  load data / store ack, 1-cycle pulse
- d_rdata  out  WORD_WIDTH  load data, zero for stores
- d_err  out  1  access rejected, with d_rvalid (see Configuration)
- mem_read, mem_write  out  1 each  to memory, never both high
- mem_unit  out  2  to memory addrUnit
- mem_addr  out  ADDR_WIDTH  to memory
- mem_wdata  out  WORD_WIDTH  to memory dataIn
- mem_rdata  in  WORD_WIDTH  from memory dataOut

## Operation
- States: IDLE, ISSUE, RESP.
- Grant possible only in IDLE or RESP. if_gnt/d_gnt are combinational from req and arbiter state; at most one high per cycle. On grant: command (owner, we, unit, addr, wdata) is registered, next state ISSUE. No request: RESP→IDLE, IDLE stays.
- ISSUE: mem_read = ~we, mem_write = we, mem_unit/addr/wdata from the command register. Always → RESP.
- RESP: owner's rvalid = 1. rdata = mem_rdata for loads, 0 for stores. Other rvalid = 0.
- Fetch commands always use mem_unit = 10 and we = 0.
- Arbitration: single requester wins. On contention, round-robin: the requester not granted last wins. The last-grant register resets to "fetch", so data wins the first contention.
- Outside ISSUE: mem_read = mem_write = 0, and mem_unit/addr/wdata hold their last values.
- Requester changing inputs while req high and not granted: the new values are used. After grant: don't-care.

## Timing
- Reset values:
  - State IDLE, last-grant = fetch.
  - All gnt/rvalid/err = 0.
  - mem_read = mem_write = 0.
  - mem_unit = 00, mem_addr = 0, mem_wdata = 0.
  - rdata outputs = 0.
- Latency: request granted in cycle N → memory command in N+1 → rvalid in N+2.
- Throughput: one access per 2 cycles. A grant in RESP (N+2) issues in N+3.
- Reset mid-access: the pending response is dropped. No rvalid is produced. A store registered by memory at the same edge may still complete.

## Configuration
- MEM_ARB_ALIGN_CHECK_EN defined:
  - A data request is illegal if it is a halfword at an odd address, a word with addr[1:0] ≠ 0, or d_unit = 11.
  - An illegal request is still granted and still passes through ISSUE, but mem_read/mem_write stay 0.
  - In RESP, d_rvalid = 1, d_err = 1, d_rdata = 0.
- MEM_ARB_ALIGN_CHECK_EN undefined:
  - No checking; all data requests are forwarded as-is.
  - d_err is tied to 0.
  - A d_unit = 11 request is forwarded unchanged.

## Structure
- Shared package (alongside the rv32i defines): mem_arb_state_t enum {IDLE, ISSUE, RESP} and mem_arb_owner_t enum {OWNER_IF, OWNER_D}.
- Reuse the existing BYTE/HALFWORD/WORD memory-mode constants; no new literals.
- One sub-module, mem_arb_rr: 2-way round-robin picker. Inputs: req vector, last-grant. Output: one-hot pick. Purely combinational.
- The top holds the FSM, command register and last-grant register.

## Test plan
- Fetch alone: if_req = 1, if_addr = 0x10, memory word 0xDEADBEEF at 0x10 → if_gnt in cycle 0, mem_read in cycle 1, if_rvalid with 0xDEADBEEF in cycle 2.
- Byte store then load:
  - Store: d_we = 1, unit 00, addr 0x21, wdata 0x000000A5 → mem_write in cycle 1, d_rvalid with d_rdata 0 in cycle 2.
  - Load at 0x21, unit 00 → d_rdata = 0x000000A5.
- Contention: if_req and d_req both held from reset → grant order D, IF, D, IF. rvalid pulses every 2 cycles, routed to the matching owner. mem_read and mem_write are never high together.
- Back-to-back: d_req held for 3 loads at 0x0, 0x4, 0x8 → d_gnt in cycles 0, 2, 4; d_rvalid in cycles 2, 4, 6.
- Align check (macro defined): word load at 0x22 → d_gnt, no mem_read, d_rvalid = d_err = 1, d_rdata = 0. With the macro undefined, the same load issues mem_read and d_err stays 0.
- Reset: assert rst_n low in ISSUE of a fetch → next cycle all outputs at reset values, no if_rvalid. After release, a new request is served normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types, widths and memory-mode constants for the mem_arbiter block.
// MEM_ARB_ALIGN_CHECK_EN (in the top) enables rejection of misaligned data accesses.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package mem_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = `ADDR_WIDTH;
  localparam int DEF_WORD_WIDTH = `WORD_WIDTH;

  localparam logic [1:0] BYTE     = 2'b00;
  localparam logic [1:0] HALFWORD = 2'b01;
  localparam logic [1:0] WORD     = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} mem_arb_state_t;
  typedef enum logic {OWNER_IF, OWNER_D} mem_arb_owner_t;

  // Unit 11 has no defined memory mode, so it is always treated as misaligned.
  function automatic logic misaligned(input logic [1:0] unit, input logic [1:0] low);
    case (unit)
      BYTE:     return 1'b0;
      HALFWORD: return low[0];
      WORD:     return (low != 2'b00);
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, on contention the
// requester that was not granted last wins. Purely combinational.
module mem_arb_rr
  import mem_arbiter_pkg::*;
(
  input  logic [1:0]     req,   // bit 0 fetch, bit 1 data
  input  mem_arb_owner_t last,
  output logic [1:0]     pick
);

  always_comb begin
    pick = req;
    if (req == 2'b11) begin
      pick = (last == OWNER_IF) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory port between fetch and load/store, one access per 2 cycles.
// Optional macro MEM_ARB_ALIGN_CHECK_EN rejects misaligned data accesses with d_err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [WORD_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [1:0]            d_unit,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [WORD_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [WORD_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            mem_unit,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output mem_arb_state_t        fsm_state
);

  mem_arb_state_t state, state_next;
  mem_arb_owner_t last_q, owner_q;
  logic           we_q, err_q;
  logic           can_grant, grant, req_illegal;
  logic [1:0]     pick;

  mem_arb_rr u_rr (
    .req  ({d_req, if_req}),
    .last (last_q),
    .pick (pick)
  );

  // Handshake: a requester holds req and its fields stable-or-updated until the
  // cycle its gnt is high; that cycle's fields are captured and the request is done.
  // The response returns as a one-cycle rvalid pulse two cycles after the grant.
  assign can_grant = rst_n && ((state == IDLE) || (state == RESP));
  assign if_gnt    = can_grant & pick[0];
  assign d_gnt     = can_grant & pick[1];
  assign grant     = if_gnt | d_gnt;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign req_illegal = misaligned(d_unit, d_addr[1:0]);
  assign d_err       = d_rvalid & err_q;
`else
  assign req_illegal = 1'b0;
  assign d_err       = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = grant ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The memory command registers double as the command register: they load only
  // on a grant, so address/unit/data hold their last values outside ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_q    <= OWNER_IF;
      owner_q   <= OWNER_IF;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_unit  <= BYTE;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_next;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      if (d_gnt) begin
        owner_q   <= OWNER_D;
        last_q    <= OWNER_D;
        we_q      <= d_we;
        err_q     <= req_illegal;
        mem_read  <= ~d_we & ~req_illegal;
        mem_write <= d_we & ~req_illegal;
        mem_unit  <= d_unit;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (if_gnt) begin
        owner_q   <= OWNER_IF;
        last_q    <= OWNER_IF;
        we_q      <= 1'b0;
        err_q     <= 1'b0;
        mem_read  <= 1'b1;
        mem_unit  <= WORD;
        mem_addr  <= if_addr;
      end
    end
  end

  assign if_rvalid = (state == RESP) && (owner_q == OWNER_IF);
  assign d_rvalid  = (state == RESP) && (owner_q == OWNER_D);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = (d_rvalid && !we_q && !err_q) ? mem_rdata : '0;
  assign fsm_state = state;

endmodule
